// File: rtl/demux_1x4_tdm.sv
// demux_1x4_tdm: locks to a 4-slot serial TDM stream with a frame-sync marker,
// deserializes each slot MSB first and publishes all four channels in parallel
// once per complete frame. Framing violations pulse sync_err.
module demux_1x4_tdm #(
    parameter int unsigned SLOT_BITS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [4*SLOT_BITS-1:0] y,
    output logic [1:0]             select,
    output logic                   locked,
    output logic                   frame_done,
    output logic                   sync_err
);

    localparam int unsigned CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sel_q, sel_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [SLOT_BITS-1:0]   sh_q [4];
    logic [SLOT_BITS-1:0]   sh_d [4];
    logic [4*SLOT_BITS-1:0] y_q, y_d;
    logic                   fd_q, fd_d;
    logic                   se_q, se_d;

    logic                   boundary;
    logic                   take;
    logic [1:0]             cur_sel;
    logic [CW-1:0]          cur_cnt;

    // State, slot/bit position, shadows and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            sel_q   <= '0;
            bcnt_q  <= '0;
            y_q     <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                sh_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bcnt_q  <= bcnt_d;
            y_q     <= y_d;
            fd_q    <= fd_d;
            se_q    <= se_d;
            for (int unsigned i = 0; i < 4; i++) begin
                sh_q[i] <= sh_d[i];
            end
        end
    end

    // Framing decisions and deserialization for one beat.
    // A frame_sync beat is always taken as position (slot 0, bit 0), so the
    // HUNT lock, a normal frame start and a mid-frame restart share one path.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        y_d      = y_q;
        fd_d     = 1'b0;
        se_d     = 1'b0;
        boundary = (sel_q == 2'd0) && (bcnt_q == '0);
        take     = 1'b0;
        cur_sel  = sel_q;
        cur_cnt  = bcnt_q;

        if (din_valid) begin
            if (frame_sync) begin
                if ((state_q == RECV) && !boundary) begin
                    se_d = 1'b1;
                end
                state_d = RECV;
                take    = 1'b1;
                cur_sel = 2'd0;
                cur_cnt = '0;
            end else if (state_q == RECV) begin
                if (boundary) begin
                    // Position is already slot 0 / bit 0, nothing else to clear.
                    se_d    = 1'b1;
                    state_d = HUNT;
                end else begin
                    take = 1'b1;
                end
            end
        end

        if (take) begin
            sh_d[cur_sel] = SLOT_BITS'({sh_q[cur_sel], din});
            if (cur_cnt == CW'(SLOT_BITS - 1)) begin
                bcnt_d = '0;
                sel_d  = cur_sel + 2'd1;
                if (cur_sel == 2'd3) begin
                    y_d  = {sh_d[3], sh_d[2], sh_d[1], sh_d[0]};
                    fd_d = 1'b1;
                end
            end else begin
                bcnt_d = cur_cnt + CW'(1);
                sel_d  = cur_sel;
            end
        end
    end

    assign y          = y_q;
    assign select     = sel_q;
    assign locked     = (state_q == RECV);
    assign frame_done = fd_q;
    assign sync_err   = se_q;

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Testbench for demux_1x4_tdm: two instances (SLOT_BITS=4 and SLOT_BITS=1) share
// one input stream; a beat-indexed frame model predicts every output each cycle.
module tb_demux_1x4_tdm;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        din_valid;
    logic        frame_sync;

    logic [15:0] y4;
    logic [1:0]  sel4;
    logic        lk4, fd4, se4;
    logic [3:0]  y1;
    logic [1:0]  sel1;
    logic        lk1, fd1, se1;

    int total = 0;
    int bad   = 0;

    demux_1x4_tdm #(.SLOT_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y(y4), .select(sel4), .locked(lk4),
        .frame_done(fd4), .sync_err(se4)
    );

    demux_1x4_tdm #(.SLOT_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y(y1), .select(sel1), .locked(lk1),
        .frame_done(fd1), .sync_err(se1)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a list of beats; position = beat index in frame.
    bit          m_lock [2];
    int          m_idx  [2];
    bit [63:0]   m_bits [2];
    logic [15:0] m_y    [2];
    bit          m_fd   [2];
    bit          m_se   [2];

    function automatic int sbof(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lock[d] = 1'b0;
            m_idx[d]  = 0;
            m_bits[d] = '0;
            m_y[d]    = '0;
            m_fd[d]   = 1'b0;
            m_se[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input bit fs, input bit dn);
        int sb;
        int fl;
        logic [15:0] t;
        sb = sbof(d);
        fl = 4 * sb;
        m_fd[d] = 1'b0;
        m_se[d] = 1'b0;
        if (v) begin
            if (fs) begin
                if (m_lock[d] && m_idx[d] != 0) m_se[d] = 1'b1;
                m_lock[d]    = 1'b1;
                m_bits[d][0] = dn;
                m_idx[d]     = 1;
            end else if (m_lock[d]) begin
                if (m_idx[d] == 0) begin
                    m_se[d]   = 1'b1;
                    m_lock[d] = 1'b0;
                end else begin
                    m_bits[d][m_idx[d]] = dn;
                    m_idx[d] = m_idx[d] + 1;
                    if (m_idx[d] == fl) begin
                        t = '0;
                        for (int k = 0; k < 4; k++)
                            for (int b = 0; b < sb; b++)
                                t[k*sb + sb - 1 - b] = m_bits[d][k*sb + b];
                        m_y[d]   = t;
                        m_fd[d]  = 1'b1;
                        m_idx[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u4.y",          {16'h0, y4},           {16'h0, m_y[0]});
        chk("u4.select",     {30'h0, sel4},         32'((m_idx[0] / 4) % 4));
        chk("u4.locked",     {31'h0, lk4},          {31'h0, m_lock[0]});
        chk("u4.frame_done", {31'h0, fd4},          {31'h0, m_fd[0]});
        chk("u4.sync_err",   {31'h0, se4},          {31'h0, m_se[0]});
        chk("u1.y",          {28'h0, y1},           {16'h0, m_y[1]});
        chk("u1.select",     {30'h0, sel1},         32'(m_idx[1] % 4));
        chk("u1.locked",     {31'h0, lk1},          {31'h0, m_lock[1]});
        chk("u1.frame_done", {31'h0, fd1},          {31'h0, m_fd[1]});
        chk("u1.sync_err",   {31'h0, se1},          {31'h0, m_se[1]});
    endtask

    task automatic beat(input bit v, input bit fs, input bit dn);
        din_valid  = v;
        frame_sync = fs;
        din        = dn;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            model_step(0, v, fs, dn);
            model_step(1, v, fs, dn);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Serial bit i of a SLOT_BITS=4 frame whose parallel image is w.
    function automatic bit bit4(input logic [15:0] w, input int i);
        logic [15:0] t;
        t = w;
        return t[4*(i/4) + 3 - (i%4)];
    endfunction

    task automatic send_frame4(input logic [15:0] w, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && ($urandom % 3 == 0)) beat(1'b0, 1'($urandom), 1'($urandom));
            beat(1'b1, i == 0, bit4(w, i));
        end
    endtask

    initial begin
        logic [15:0] p, wa, wb;
        logic [3:0]  pat;

        reset = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Contiguous SLOT_BITS=4 frame 1010 0101 1111 0000.
        p = 16'b1010_0101_1111_0000;
        for (int i = 0; i < 16; i++) beat(1'b1, i == 0, p[15 - i]);
        chk("tp1.y",          {16'h0, y4}, 32'h0F5A);
        chk("tp1.frame_done", {31'h0, fd4}, 32'd1);
        chk("tp1.locked",     {31'h0, lk4}, 32'd1);
        beat(1'b0, 1'b0, 1'b0);
        chk("tp1.fd_pulse",   {31'h0, fd4}, 32'd0);

        // SLOT_BITS=1: beats 1,0,1,1 with random idle gaps.
        do_reset();
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) beat(1'b0, 1'($urandom), 1'($urandom));
            beat(1'b1, i == 0, pat[i]);
            chk("tp2.select", {30'h0, sel1}, 32'((i + 1) % 4));
        end
        chk("tp2.y", {28'h0, y1}, 32'hD);

        // Second frame missing its sync, then relock.
        do_reset();
        wa = 16'($urandom);
        wb = 16'($urandom);
        send_frame4(wa, 1'b0);
        chk("tp3.yA", {16'h0, y4}, {16'h0, wa});
        beat(1'b1, 1'b0, 1'($urandom));
        chk("tp3.sync_err", {31'h0, se4}, 32'd1);
        chk("tp3.locked",   {31'h0, lk4}, 32'd0);
        chk("tp3.y_hold",   {16'h0, y4}, {16'h0, wa});
        repeat (5) beat(1'b1, 1'b0, 1'($urandom));
        send_frame4(wb, 1'b1);
        chk("tp3.relock", {31'h0, lk4}, 32'd1);
        chk("tp3.yB",     {16'h0, y4}, {16'h0, wb});

        // frame_sync on beat 6 restarts the frame.
        do_reset();
        wa = 16'($urandom);
        wb = 16'($urandom);
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, bit4(wa, i));
        beat(1'b1, 1'b1, bit4(wb, 0));
        chk("tp4.sync_err", {31'h0, se4}, 32'd1);
        for (int i = 1; i < 16; i++) beat(1'b1, 1'b0, bit4(wb, i));
        chk("tp4.frame_done", {31'h0, fd4}, 32'd1);
        chk("tp4.y",          {16'h0, y4}, {16'h0, wb});

        // Asynchronous reset between clock edges mid-frame.
        wa = 16'($urandom) | 16'h0001;
        send_frame4(wa, 1'b0);
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'($urandom));
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("tp5.y",      {16'h0, y4}, 32'h0);
        chk("tp5.select", {30'h0, sel4}, 32'h0);
        chk("tp5.locked", {31'h0, lk4}, 32'h0);
        check_all();
        beat(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        repeat (6) beat(1'b1, 1'b0, 1'($urandom));
        chk("tp5.ignored", {31'h0, lk4}, 32'h0);
        wb = 16'($urandom);
        send_frame4(wb, 1'b1);
        chk("tp5.y_after", {16'h0, y4}, {16'h0, wb});

        // Noise without frame_sync while hunting.
        do_reset();
        repeat (20) beat(1'b1, 1'b0, 1'($urandom));
        chk("tp6.locked", {31'h0, lk4}, 32'h0);
        chk("tp6.y",      {16'h0, y4}, 32'h0);

        // Randomized frames with gaps, occasional missing or stray syncs.
        for (int f = 0; f < 40; f++) begin
            wa = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                if ($urandom % 4 == 0) beat(1'b0, 1'($urandom), 1'($urandom));
                beat(1'b1, (i == 0) ? ($urandom % 10 != 0) : ($urandom % 40 == 0),
                     bit4(wa, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
